// File: rtl/div_sched.sv
// rtl/div_sched.sv - run-time integer clock divider with 50% duty and glitch-free ratio changes
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   enable              run request (level); start immediate, stop at period end
//   cfg_valid/cfg_div   offered divide ratio N; cfg_ready accepts it
//   cfg_err             one-cycle pulse when an offered ratio (<2) is discarded
//   cur_div             ratio currently in effect
//   running             divider active
//   tick                one-cycle pulse on the first clk cycle of each output period
//   clk_out             divided clock, 50% duty for odd and even N
`timescale 1ns/1ps
module div_sched #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             running,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt, cnt_nx, cur_nx, pend_div, pend_nx, half_nx;
  logic             pend_vld, pend_vld_nx, run_nx;
  logic             p, p_n;
  logic             xfer, legal, terminal;

  assign cfg_ready = ~pend_vld;
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = (cfg_div[CNT_W-1:1] != '0);
  assign terminal  = running & (cnt == cur_div - ONE);

  always_comb begin
    cnt_nx      = cnt;
    cur_nx      = cur_div;
    pend_nx     = pend_div;
    pend_vld_nx = pend_vld;
    run_nx      = running;
    if (running) begin
      if (terminal) begin
        // Period boundary: the only place a new ratio or a stop may take effect.
        cnt_nx = '0;
        run_nx = enable;
        if (pend_vld) begin
          cur_nx      = pend_div;
          pend_vld_nx = 1'b0;
        end
      end else begin
        cnt_nx = cnt + ONE;
      end
    end else begin
      cnt_nx = '0;
      run_nx = enable;
      if (pend_vld) begin
        cur_nx      = pend_div;
        pend_vld_nx = 1'b0;
      end
    end
    // A transfer needs pend_vld=0, so it never collides with the clear above;
    // one landing on a terminal cycle waits for the following boundary.
    if (xfer && legal) begin
      pend_nx     = cfg_div;
      pend_vld_nx = 1'b1;
    end
    // High-phase length ceil(N/2), formed without an N+1 that could overflow.
    half_nx = (cur_nx >> 1) + {{(CNT_W-1){1'b0}}, cur_nx[0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      cur_div  <= DEF;
      pend_div <= DEF;
      pend_vld <= 1'b0;
      running  <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      p        <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      cur_div  <= cur_nx;
      pend_div <= pend_nx;
      pend_vld <= pend_vld_nx;
      running  <= run_nx;
      tick     <= run_nx & (cnt_nx == '0);
      cfg_err  <= xfer & ~legal;
      p        <= run_nx & (cnt_nx < half_nx);
    end
  end

  // Half-cycle delayed copy of p; ANDing it in trims the odd-N high phase by
  // half a clk period, giving exactly N/2 high.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) p_n <= 1'b0;
    else       p_n <= p;
  end

  assign clk_out = cur_div[0] ? (p & p_n) : p;

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
Run-time controller for an integer clock divider. It owns the divide counter and produces a 50%-duty divided clock for both odd and even ratios. It accepts new divide ratios through a valid/ready handshake and applies them only at output-period boundaries, so clk_out never glitches or produces a runt pulse. It also provides start/stop gating and a per-period tick for downstream sequencing.

Parameters:
CNT_W, 8, width of divide ratio and internal counter
DEF_DIV, 7, divide ratio loaded at reset (must be 2..2^CNT_W-1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  run request; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_div  input  CNT_W  offered divide ratio N
cfg_ready  output  1  controller can accept a ratio
cfg_err  output  1  one-cycle pulse: offered ratio illegal (<2), discarded
cur_div  output  CNT_W  ratio currently in effect
running  output  1  divider active
tick  output  1  one-cycle pulse on first clk cycle of each output period
clk_out  output  1  divided clock

Behaviour:
- Reset (async, active-high): cnt=0, cur_div=DEF_DIV, pending empty, cfg_ready=1, cfg_err=0, running=0, tick=0, clk_out=0. The negedge phase flop also resets to 0.
- Counter: while running, cnt counts 0..cur_div-1 on each posedge and then wraps to 0. When not running, cnt is held at 0.
- tick = running & (cnt==0), registered. It is high for exactly one clk cycle per period.
- Phase p (posedge register):
  - Even N: p=1 for cnt in [0, N/2-1]; clk_out=p (high N/2 cycles).
  - Odd N: p=1 for cnt in [0, (N-1)/2]. p_n captures p on negedge clk. clk_out = p & p_n, giving a high time of N/2 clk periods (e.g. N=7 gives 3.5 cycles).
  - Parity is taken from cur_div.
- Handshake: a transfer occurs when cfg_valid & cfg_ready on a posedge.
  - cfg_ready = ~pend_vld.
  - Legal N (>=2): written to pend_div and pend_vld is set.
  - Illegal N (0 or 1): accepted but discarded. cfg_err pulses in the next cycle; pend_vld and cur_div are unchanged.
- Ratio application:
  - Running: applied on the terminal cycle (cnt==cur_div-1). Next cycle has cnt=0 and cur_div=pend_div, then pend_vld clears and cfg_ready returns to 1.
  - A transfer that lands on a terminal cycle is not applied at that boundary; it waits for the next one.
  - Not running: applied in the cycle after the transfer.
- Start: enable sampled 1 while running=0 sets running=1 next cycle. The first active cycle has cnt=0, tick=1 and p high.
- Stop: enable sampled 0 while running is honoured only on the terminal cycle. The current period completes, then running=0 and clk_out returns to 0 (the odd-N negedge half finishes naturally).
- Enable toggled 1→0→1 within one period: no effect, no extra tick.
- Reset mid-period: clk_out drops immediately (async). Any pending ratio is lost and cur_div returns to DEF_DIV.
- Constraint: the counter compare uses CNT_W bits. N up to 2^CNT_W-1 is supported with no overflow.

Test Plan:
- Reset asserted 0-198 ns, enable=1 after, clk 20 ns → tick every 140 ns; clk_out period 140 ns, high 70 ns (check both edges); cur_div=7.
- At cnt=3, offer cfg_div=4 → cfg_ready low until boundary; current 7-cycle period completes; then clk_out period 80 ns, high 40 ns; cur_div=4.
- Offer cfg_div=1 → cfg_err pulses once, cur_div stays 7, clk_out unchanged; offer 0 → same.
- Offer 5 then 9 back-to-back with cfg_valid held → 9 stalls (cfg_ready=0) until 5 applies; sequence 7→5→9 periods observed with no runt pulses.
- enable low at cnt=2 of N=7 → period completes (tick count unchanged), then clk_out=0, running=0; enable high → tick on first cycle, period 140 ns.
- Assert reset at cnt=5 with pending ratio 3 → clk_out=0 immediately; after release and enable, cur_div=7 and pending is discarded.
